// File: rtl/pc_fetch_controller.sv
`default_nettype none
// ============================================================================
// Module   : pc_fetch_controller
// Purpose  : PC sequencing and IF-stage control: next-PC select, pipeline
//            write/flush controls, pending redirects, boot delay, stall watchdog.
// Revision : 1.0 - initial release
// ============================================================================
module pc_fetch_controller #(
  parameter int XLEN        = 32,
  parameter int BOOT_WAIT   = 2,
  parameter int STALL_LIMIT = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_imem_ready,
  input  logic             i_stall_req,
  input  logic             i_branch_taken,
  input  logic [XLEN-1:0]  i_branch_target,
  input  logic             i_jump_req,
  input  logic [XLEN-1:0]  i_jump_offset,
  output logic             o_pc_en,
  output logic [1:0]       o_pc_sel,
  output logic [XLEN-1:0]  o_next_target,
  output logic             o_if_id_write,
  output logic             o_if_id_flush,
  output logic             o_id_ex_flush,
  output logic             o_fetch_valid,
  output logic             o_stall_timeout,
  output logic [CNT_W-1:0] o_redirect_count
);

  typedef enum logic [1:0] {
    S_BOOT     = 2'd0,
    S_RUN      = 2'd1,
    S_WAIT_MEM = 2'd2
  } state_t;

  localparam logic [1:0] C_SEL_SEQ  = 2'd0;
  localparam logic [1:0] C_SEL_ABS  = 2'd1;
  localparam logic [1:0] C_SEL_REL  = 2'd2;
  localparam logic [1:0] C_SEL_HOLD = 2'd3;
  localparam logic [3:0] C_BOOT_LAST = 4'(BOOT_WAIT - 1);
  localparam logic [7:0] C_STALL_MAX = 8'(STALL_LIMIT);

  state_t            r_state;
  state_t            w_state_next;
  logic [3:0]        r_boot_cnt;
  logic [1:0]        r_pend_kind;
  logic [XLEN-1:0]   r_pend_target;
  logic [7:0]        r_stall_cnt;
  logic [7:0]        w_stall_next;
  logic              r_stall_timeout;
  logic [CNT_W-1:0]  r_redirect_count;

  logic [1:0]        w_pc_sel;
  logic [XLEN-1:0]   w_next_target;
  logic              w_if_id_write;
  logic              w_if_id_flush;
  logic              w_id_ex_flush;
  logic              w_stall_win;
  logic              w_pc_en;
  logic              w_is_redirect;

  always_comb begin
    w_state_next  = r_state;
    w_pc_sel      = C_SEL_HOLD;
    w_next_target = '0;
    w_if_id_write = 1'b0;
    w_if_id_flush = 1'b0;
    w_id_ex_flush = 1'b0;
    w_stall_win   = 1'b0;
    case (r_state)
      S_BOOT: begin
        if (r_boot_cnt == C_BOOT_LAST) w_state_next = S_RUN;
      end
      S_RUN: begin
        if (i_branch_taken) begin
          w_pc_sel      = C_SEL_ABS;
          w_next_target = i_branch_target;
          w_if_id_write = 1'b1;
          w_if_id_flush = 1'b1;
          w_id_ex_flush = 1'b1;
          if (!i_imem_ready) w_state_next = S_WAIT_MEM;
        end else if (i_jump_req && !i_stall_req) begin
          w_pc_sel      = C_SEL_REL;
          w_next_target = i_jump_offset;
          w_if_id_write = 1'b1;
          w_if_id_flush = 1'b1;
          if (!i_imem_ready) w_state_next = S_WAIT_MEM;
        end else if (i_stall_req) begin
          w_id_ex_flush = 1'b1;
          w_stall_win   = 1'b1;
        end else begin
          w_pc_sel      = C_SEL_SEQ;
          w_if_id_write = 1'b1;
        end
      end
      S_WAIT_MEM: begin
        // A late branch supersedes whatever redirect is still waiting.
        w_if_id_write = 1'b1;
        if (i_branch_taken) begin
          w_pc_sel      = C_SEL_ABS;
          w_next_target = i_branch_target;
          w_if_id_flush = 1'b1;
          w_id_ex_flush = 1'b1;
        end else begin
          w_pc_sel      = r_pend_kind;
          w_next_target = r_pend_target;
        end
        if (i_imem_ready) w_state_next = S_RUN;
      end
      default: w_state_next = S_BOOT;
    endcase
  end

  assign w_pc_en       = i_imem_ready && (w_pc_sel != C_SEL_HOLD);
  assign w_is_redirect = (w_pc_sel == C_SEL_ABS) || (w_pc_sel == C_SEL_REL);
  assign w_stall_next  = !w_stall_win ? 8'd0 :
                         (r_stall_cnt == C_STALL_MAX) ? r_stall_cnt : r_stall_cnt + 8'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state          <= S_BOOT;
      r_boot_cnt       <= 4'd0;
      r_pend_kind      <= C_SEL_SEQ;
      r_pend_target    <= '0;
      r_stall_cnt      <= 8'd0;
      r_stall_timeout  <= 1'b0;
      r_redirect_count <= '0;
    end else begin
      r_state     <= w_state_next;
      r_stall_cnt <= w_stall_next;
      if (w_stall_next == C_STALL_MAX) r_stall_timeout <= 1'b1;
      if (r_state == S_BOOT && r_boot_cnt != C_BOOT_LAST) r_boot_cnt <= r_boot_cnt + 4'd1;
      if (w_is_redirect && !i_imem_ready) begin
        r_pend_kind   <= w_pc_sel;
        r_pend_target <= w_next_target;
      end else if (i_imem_ready) begin
        r_pend_kind   <= C_SEL_SEQ;
        r_pend_target <= '0;
      end
      if (w_pc_en && w_is_redirect) r_redirect_count <= r_redirect_count + 1'b1;
    end
  end

  assign o_pc_en          = w_pc_en;
  assign o_pc_sel         = w_pc_sel;
  assign o_next_target    = w_next_target;
  assign o_if_id_write    = w_if_id_write;
  assign o_if_id_flush    = w_if_id_flush;
  assign o_id_ex_flush    = w_id_ex_flush;
  assign o_fetch_valid    = (r_state != S_BOOT) && i_imem_ready && !w_if_id_flush && !w_id_ex_flush;
  assign o_stall_timeout  = r_stall_timeout;
  assign o_redirect_count = r_redirect_count;

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_fetch_controller
// Purpose  : Randomized + directed bench for pc_fetch_controller against a
//            behavioural model. Revision : 1.0 - initial release
// ============================================================================
module tb_pc_fetch_controller;
  localparam int XLEN = 32, BOOT_WAIT = 2, STALL_LIMIT = 16, CNT_W = 16;

  logic clk = 1'b0;
  logic rst_n;
  logic i_imem_ready, i_stall_req, i_branch_taken, i_jump_req;
  logic [XLEN-1:0] i_branch_target, i_jump_offset;
  logic o_pc_en, o_if_id_write, o_if_id_flush, o_id_ex_flush, o_fetch_valid, o_stall_timeout;
  logic [1:0] o_pc_sel;
  logic [XLEN-1:0] o_next_target;
  logic [CNT_W-1:0] o_redirect_count;

  always #5 clk = ~clk;

  pc_fetch_controller #(.XLEN(XLEN), .BOOT_WAIT(BOOT_WAIT), .STALL_LIMIT(STALL_LIMIT), .CNT_W(CNT_W)) u_dut (
    .clk(clk), .rst_n(rst_n), .i_imem_ready(i_imem_ready), .i_stall_req(i_stall_req),
    .i_branch_taken(i_branch_taken), .i_branch_target(i_branch_target),
    .i_jump_req(i_jump_req), .i_jump_offset(i_jump_offset),
    .o_pc_en(o_pc_en), .o_pc_sel(o_pc_sel), .o_next_target(o_next_target),
    .o_if_id_write(o_if_id_write), .o_if_id_flush(o_if_id_flush), .o_id_ex_flush(o_id_ex_flush),
    .o_fetch_valid(o_fetch_valid), .o_stall_timeout(o_stall_timeout), .o_redirect_count(o_redirect_count)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Behavioural model: boot cycles left, pending redirect, stall run length.
  int              m_boot_left;
  bit              m_pend;
  logic [1:0]      m_pend_kind;
  logic [XLEN-1:0] m_pend_tgt;
  int              m_stall_run;
  bit              m_timeout;
  logic [CNT_W-1:0] m_count;

  logic            e_pc_en, e_if_id_write, e_if_flush, e_idex_flush, e_fetch_valid;
  logic [1:0]      e_sel;
  logic [XLEN-1:0] e_tgt;
  bit              e_stall_win;

  task automatic m_reset();
    m_boot_left = BOOT_WAIT;
    m_pend = 0; m_pend_kind = 2'd0; m_pend_tgt = '0;
    m_stall_run = 0; m_timeout = 0; m_count = '0;
  endtask

  task automatic model_eval();
    e_sel = 2'd3; e_tgt = '0; e_if_id_write = 0; e_if_flush = 0; e_idex_flush = 0;
    e_stall_win = 0; e_pc_en = 0; e_fetch_valid = 0;
    if (rst_n === 1'b1 && m_boot_left == 0) begin
      if (m_pend) begin
        e_if_id_write = 1;
        if (i_branch_taken) begin
          e_sel = 2'd1; e_tgt = i_branch_target; e_if_flush = 1; e_idex_flush = 1;
        end else begin
          e_sel = m_pend_kind; e_tgt = m_pend_tgt;
        end
      end else if (i_branch_taken) begin
        e_sel = 2'd1; e_tgt = i_branch_target; e_if_flush = 1; e_idex_flush = 1; e_if_id_write = 1;
      end else if (i_jump_req && !i_stall_req) begin
        e_sel = 2'd2; e_tgt = i_jump_offset; e_if_flush = 1; e_if_id_write = 1;
      end else if (i_stall_req) begin
        e_idex_flush = 1; e_stall_win = 1;
      end else begin
        e_sel = 2'd0; e_if_id_write = 1;
      end
      e_pc_en = i_imem_ready && (e_sel != 2'd3);
      e_fetch_valid = i_imem_ready && !e_if_flush && !e_idex_flush;
    end
  endtask

  task automatic model_update();
    if (rst_n !== 1'b1) begin
      m_reset();
    end else if (m_boot_left > 0) begin
      m_boot_left--;
    end else begin
      if (e_pc_en && (e_sel == 2'd1 || e_sel == 2'd2)) m_count++;
      if (e_sel == 2'd1 || e_sel == 2'd2) begin
        m_pend = !i_imem_ready;
        if (!i_imem_ready) begin m_pend_kind = e_sel; m_pend_tgt = e_tgt; end
      end
      m_stall_run = e_stall_win ? ((m_stall_run < STALL_LIMIT) ? m_stall_run + 1 : m_stall_run) : 0;
      if (m_stall_run == STALL_LIMIT) m_timeout = 1;
    end
  endtask

  task automatic compare_all();
    check("pc_en",          64'(o_pc_en),          64'(e_pc_en));
    check("pc_sel",         64'(o_pc_sel),         64'(e_sel));
    check("next_target",    64'(o_next_target),    64'(e_tgt));
    check("if_id_write",    64'(o_if_id_write),    64'(e_if_id_write));
    check("if_id_flush",    64'(o_if_id_flush),    64'(e_if_flush));
    check("id_ex_flush",    64'(o_id_ex_flush),    64'(e_idex_flush));
    check("fetch_valid",    64'(o_fetch_valid),    64'(e_fetch_valid));
    check("stall_timeout",  64'(o_stall_timeout),  64'(m_timeout));
    check("redirect_count", 64'(o_redirect_count), 64'(m_count));
  endtask

  task automatic step();
    @(negedge clk);
    model_eval();
    compare_all();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic drive(input bit rdy, input bit br, input logic [XLEN-1:0] bt,
                       input bit jr, input logic [XLEN-1:0] jo, input bit st);
    i_imem_ready = rdy; i_branch_taken = br; i_branch_target = bt;
    i_jump_req = jr; i_jump_offset = jo; i_stall_req = st;
  endtask

  initial begin
    rst_n = 1'b0;
    m_reset();
    drive(1, 0, '0, 0, '0, 0);
    step(); step();
    rst_n = 1'b1;
    // Boot: hold for BOOT_WAIT cycles, then sequential fetch.
    for (int i = 0; i < 4; i++) step();
    check("boot_done_pc_en", 64'(o_pc_en), 64'd1);

    drive(1, 1, 32'h40, 1, 32'd7, 1); step();
    drive(1, 0, '0, 0, '0, 0); step();
    check("branch_count", 64'(o_redirect_count), 64'd1);

    drive(1, 0, '0, 1, 32'd5, 1); step();
    drive(1, 0, '0, 1, 32'd5, 0); step();
    drive(1, 0, '0, 0, '0, 0); step();

    drive(0, 1, 32'h80, 0, '0, 0); step();
    drive(0, 0, '0, 1, 32'd9, 1); step(); step();
    drive(1, 0, '0, 0, '0, 0); step(); step();

    drive(1, 0, '0, 0, '0, 1);
    for (int i = 0; i < STALL_LIMIT; i++) step();
    drive(1, 0, '0, 0, '0, 0); step(); step();
    check("timeout_sticky", 64'(o_stall_timeout), 64'd1);

    // Asynchronous reset while a redirect is pending.
    drive(0, 1, 32'h1234, 0, '0, 0); step();
    drive(0, 0, '0, 0, '0, 0);
    rst_n = 1'b0;
    m_reset();
    #1;
    model_eval();
    compare_all();
    step();
    rst_n = 1'b1;
    drive(1, 0, '0, 0, '0, 0);
    for (int i = 0; i < 4; i++) step();

    for (int i = 0; i < 2000; i++) begin
      drive(($urandom % 4) != 0, ($urandom % 8) == 0, $urandom,
            ($urandom % 6) == 0, $urandom, ($urandom % 5) == 0);
      if (($urandom % 150) == 0) begin
        rst_n = 1'b0;
        m_reset();
      end else begin
        rst_n = 1'b1;
      end
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
`default_nettype wire
